tft_ili9341_rx: RTL and testbench

- SPI panel-side receiver for the ILI9341 4-wire serial protocol: the responder end of our TFT driver link.
- Deserialises the SCK/SDI/DC/CS stream, decodes the command subset our driver emits, tracks the CASET/PASET window, and turns RAMWR data into addressed RGB565 pixel writes.
- Used in simulation as a panel model, and on-chip to mirror display traffic into a capture framebuffer.

---
 rtl/tft_ili9341_pkg.sv | 16 +
 rtl/tft_ili9341_spi_rx.sv | 53 +++++
 rtl/tft_ili9341_rx.sv | 142 ++++++++++++++
 tb/tb_tft_ili9341_rx.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/tft_ili9341_pkg.sv
// tft_ili9341_pkg: opcodes, receiver states and coordinate type for the ILI9341 panel-side receiver
package tft_ili9341_pkg;
  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_SLPIN   = 8'h10;
  localparam logic [7:0] OP_SLPOUT  = 8'h11;
  localparam logic [7:0] OP_DISPOFF = 8'h28;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_PASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;
  localparam logic [7:0] OP_MADCTL  = 8'h36;
  localparam logic [7:0] OP_COLMOD  = 8'h3A;
  localparam logic [7:0] OP_RAMWRC  = 8'h3C;
  typedef enum logic [2:0] {IDLE, PARAM4, PARAM1, RAMWR, IGNORE} rx_state_t;
  typedef logic [8:0] coord_t;
endpackage

// File: rtl/tft_ili9341_spi_rx.sv
// tft_ili9341_spi_rx: synchronises the 4-wire SPI pins and deserialises mode-0 bytes with their D/C flag
module tft_ili9341_spi_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tft_sck,
  input  logic       tft_sdi,
  input  logic       tft_dc,
  input  logic       tft_cs,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);
  logic [SYNC_STAGES-1:0] sck_sr, sdi_sr, dc_sr, cs_sr;
  logic sck_d, rise;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  assign rise = sck_sr[SYNC_STAGES-1] & ~sck_d & ~cs_sr[SYNC_STAGES-1];
  // CS synchroniser resets to deselected so no edge is seen before the pin propagates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_sr <= '0;
      sdi_sr <= '0;
      dc_sr <= '0;
      cs_sr <= '1;
      sck_d <= 1'b0;
      bit_cnt <= '0;
      shreg <= '0;
      byte_valid <= 1'b0;
      byte_data <= '0;
      byte_dc <= 1'b0;
    end else begin
      sck_sr <= {sck_sr[SYNC_STAGES-2:0], tft_sck};
      sdi_sr <= {sdi_sr[SYNC_STAGES-2:0], tft_sdi};
      dc_sr <= {dc_sr[SYNC_STAGES-2:0], tft_dc};
      cs_sr <= {cs_sr[SYNC_STAGES-2:0], tft_cs};
      sck_d <= sck_sr[SYNC_STAGES-1];
      byte_valid <= 1'b0;
      if (cs_sr[SYNC_STAGES-1]) begin
        bit_cnt <= '0;
      end else if (rise) begin
        shreg <= {shreg[5:0], sdi_sr[SYNC_STAGES-1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data <= {shreg, sdi_sr[SYNC_STAGES-1]};
          byte_dc <= dc_sr[SYNC_STAGES-1];
        end
      end
    end
  end
endmodule

// File: rtl/tft_ili9341_rx.sv
// tft_ili9341_rx: ILI9341 serial responder that decodes driver commands and emits addressed RGB565 pixel writes
module tft_ili9341_rx
  import tft_ili9341_pkg::*;
#(
  parameter int SYNC_STAGES      = 2,
  parameter int COL_END_DEFAULT  = 239,
  parameter int PAGE_END_DEFAULT = 319
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tft_sck,
  input  logic        tft_sdi,
  input  logic        tft_dc,
  input  logic        tft_cs,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        pix_valid,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        display_on,
  output logic        sleep_out,
  output logic [7:0]  madctl,
  output logic [7:0]  colmod
);
  localparam coord_t COL_END = coord_t'(COL_END_DEFAULT);
  localparam coord_t PAGE_END = coord_t'(PAGE_END_DEFAULT);
  logic byte_valid, byte_dc, is_cmd, is_dat, hi_ok, p_end_hi;
  logic [7:0] byte_data, hi;
  logic [1:0] pcnt;
  rx_state_t state, state_n;
  coord_t x, y, sc, ec, sp, ep, x_n, y_n, p_start;
  tft_ili9341_spi_rx #(.SYNC_STAGES(SYNC_STAGES)) u_spi (
    .clk(clk), .rst_n(rst_n), .tft_sck(tft_sck), .tft_sdi(tft_sdi), .tft_dc(tft_dc), .tft_cs(tft_cs),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc)
  );
  assign is_cmd = byte_valid & ~byte_dc;
  assign is_dat = byte_valid & byte_dc;
  assign x_n = (x >= ec) ? sc : x + 9'd1;
  assign y_n = (x >= ec) ? ((y >= ep) ? sp : y + 9'd1) : y;
  always_comb begin
    state_n = state;
    if (is_cmd)
      case (byte_data)
        OP_CASET, OP_PASET:  state_n = PARAM4;
        OP_MADCTL, OP_COLMOD: state_n = PARAM1;
        OP_RAMWR, OP_RAMWRC: state_n = RAMWR;
        default:             state_n = IGNORE;
      endcase
    else if (is_dat && ((state == PARAM4 && pcnt == 2'd3) || state == PARAM1))
      state_n = IGNORE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // cmd_byte doubles as the record of which PARAM command is being collected
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_byte <= '0;
      pix_valid <= 1'b0;
      pix_x <= '0;
      pix_y <= '0;
      pix_data <= '0;
      display_on <= 1'b0;
      sleep_out <= 1'b0;
      madctl <= '0;
      colmod <= '0;
      x <= '0;
      y <= '0;
      sc <= '0;
      sp <= '0;
      ec <= COL_END;
      ep <= PAGE_END;
      pcnt <= '0;
      p_start <= '0;
      p_end_hi <= 1'b0;
      hi <= '0;
      hi_ok <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      pix_valid <= 1'b0;
      if (is_cmd) begin
        cmd_valid <= 1'b1;
        cmd_byte <= byte_data;
        pcnt <= '0;
        hi_ok <= 1'b0;
        case (byte_data)
          OP_SWRESET: begin
            sc <= '0;
            sp <= '0;
            ec <= COL_END;
            ep <= PAGE_END;
            madctl <= '0;
            colmod <= '0;
            display_on <= 1'b0;
            sleep_out <= 1'b0;
          end
          OP_SLPIN:   sleep_out <= 1'b0;
          OP_SLPOUT:  sleep_out <= 1'b1;
          OP_DISPOFF: display_on <= 1'b0;
          OP_DISPON:  display_on <= 1'b1;
          OP_RAMWR: begin
            x <= sc;
            y <= sp;
          end
          default: ;
        endcase
      end else if (is_dat && state == PARAM4) begin
        pcnt <= pcnt + 2'd1;
        case (pcnt)
          2'd0: p_start[8] <= byte_data[0];
          2'd1: p_start[7:0] <= byte_data;
          2'd2: p_end_hi <= byte_data[0];
          default:
            if (cmd_byte == OP_CASET) begin
              sc <= p_start;
              ec <= {p_end_hi, byte_data};
            end else begin
              sp <= p_start;
              ep <= {p_end_hi, byte_data};
            end
        endcase
      end else if (is_dat && state == PARAM1) begin
        if (cmd_byte == OP_MADCTL) madctl <= byte_data;
        else colmod <= byte_data;
      end else if (is_dat && state == RAMWR) begin
        hi_ok <= ~hi_ok;
        if (!hi_ok) hi <= byte_data;
        else begin
          pix_valid <= 1'b1;
          pix_x <= x;
          pix_y <= y;
          pix_data <= {hi, byte_data};
          x <= x_n;
          y <= y_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_tft_ili9341_rx.sv
// tb_tft_ili9341_rx: scoreboard bench driving SPI traffic into tft_ili9341_rx and checking commands, pixels and status
module tb_tft_ili9341_rx;
  logic clk = 1'b0, rst_n = 1'b0;
  logic tft_sck = 1'b0, tft_sdi = 1'b0, tft_dc = 1'b0, tft_cs = 1'b1;
  logic cmd_valid, pix_valid, display_on, sleep_out;
  logic [7:0] cmd_byte, madctl, colmod;
  logic [8:0] pix_x, pix_y;
  logic [15:0] pix_data;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] cq[$];
  logic [33:0] pq[$];
  always #5 clk = ~clk;
  tft_ili9341_rx dut (
    .clk(clk), .rst_n(rst_n), .tft_sck(tft_sck), .tft_sdi(tft_sdi), .tft_dc(tft_dc), .tft_cs(tft_cs),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_data(pix_data), .display_on(display_on), .sleep_out(sleep_out), .madctl(madctl), .colmod(colmod)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic spi_bits(input logic dc, input logic [7:0] b, input int n);
    tft_cs = 1'b0;
    tft_dc = dc;
    for (int i = 7; i > 7 - n; i--) begin
      tft_sdi = b[i];
      #20 tft_sck = 1'b1;
      #20 tft_sck = 1'b0;
    end
  endtask
  task automatic cmd(input logic [7:0] b);
    cq.push_back(b);
    spi_bits(1'b0, b, 8);
    tft_cs = 1'b1;
    #20;
  endtask
  task automatic dat(input logic [7:0] b);
    spi_bits(1'b1, b, 8);
  endtask
  task automatic px(input int xx, input int yy, input logic [15:0] d);
    pq.push_back({9'(xx), 9'(yy), d});
    dat(d[15:8]);
    dat(d[7:0]);
  endtask
  task automatic win(input logic [7:0] op, input logic [15:0] s, input logic [15:0] e);
    cmd(op);
    dat(s[15:8]);
    dat(s[7:0]);
    dat(e[15:8]);
    dat(e[7:0]);
  endtask
  task automatic settle();
    repeat (8) @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (cmd_valid && pix_valid) chk("cmd_pix_overlap", 1, 0);
    if (cmd_valid) begin
      if (cq.size() == 0) chk("cmd_unexpected", {56'd0, cmd_byte}, 64'hFFFF);
      else chk("cmd_byte", cmd_byte, cq.pop_front());
    end
    if (pix_valid) begin
      if (pq.size() == 0) chk("pix_unexpected", {pix_x, pix_y, pix_data}, 64'hFFFF_FFFF_FFFF);
      else chk("pix_xyd", {pix_x, pix_y, pix_data}, pq.pop_front());
    end
  end
  initial begin
    int tx[5] = '{5, 6, 5, 6, 5};
    int ty[5] = '{10, 10, 11, 11, 10};
    repeat (4) @(negedge clk);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_cmd_byte", cmd_byte, 0);
    chk("rst_display_on", display_on, 0);
    chk("rst_sleep_out", sleep_out, 0);
    chk("rst_madctl", madctl, 0);
    chk("rst_colmod", colmod, 0);
    chk("rst_pix", {pix_x, pix_y, pix_data}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    cmd(8'h2C);
    pq.push_back({9'd0, 9'd0, 16'hF800});
    pq.push_back({9'd1, 9'd0, 16'h07E0});
    dat(8'hF8);
    dat(8'h00);
    dat(8'h07);
    dat(8'hE0);
    win(8'h2A, 16'h0005, 16'h0006);
    win(8'h2B, 16'h000A, 16'h000B);
    cmd(8'h2C);
    for (int i = 0; i < 5; i++) px(tx[i], ty[i], 16'($urandom));
    cmd(8'h2A);
    dat(8'h00);
    dat(8'h01);
    cmd(8'h2C);
    px(5, 10, 16'hA5C3);
    cmd(8'h36);
    dat(8'h48);
    cmd(8'h3A);
    dat(8'h55);
    dat(8'h99);
    settle();
    chk("madctl", madctl, 8'h48);
    chk("colmod_extra_ignored", colmod, 8'h55);
    win(8'h2A, 16'h013E, 16'h013F);
    win(8'h2B, 16'h00EF, 16'h00EF);
    cmd(8'h2C);
    px(318, 239, 16'h1234);
    win(8'h2A, 16'h0000, 16'h013F);
    win(8'h2B, 16'h0000, 16'h00EF);
    cmd(8'h3C);
    px(319, 239, 16'hBEEF);
    px(0, 0, 16'hCAFE);
    cmd(8'h2C);
    dat(8'h55);
    cmd(8'h29);
    settle();
    chk("display_on_set", display_on, 1);
    chk("sleep_before", sleep_out, 0);
    spi_bits(1'b0, 8'hFF, 5);
    tft_cs = 1'b1;
    #40;
    cmd(8'h11);
    settle();
    chk("sleep_out_set", sleep_out, 1);
    cmd(8'h28);
    cmd(8'h10);
    settle();
    chk("display_off", display_on, 0);
    chk("sleep_in", sleep_out, 0);
    cmd(8'h29);
    cmd(8'h36);
    dat(8'hC8);
    cmd(8'h01);
    settle();
    chk("swreset_madctl", madctl, 0);
    chk("swreset_colmod", colmod, 0);
    chk("swreset_display", display_on, 0);
    cmd(8'h2C);
    px(0, 0, 16'h0F0F);
    win(8'h2A, 16'h0010, 16'h0020);
    win(8'h2B, 16'h0010, 16'h0020);
    cmd(8'h29);
    cmd(8'h3A);
    dat(8'h66);
    cmd(8'h2C);
    dat(8'h12);
    spi_bits(1'b1, 8'h34, 4);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tft_cs = 1'b1;
    chk("midrst_display", display_on, 0);
    chk("midrst_colmod", colmod, 0);
    chk("midrst_cmd_byte", cmd_byte, 0);
    #40;
    cmd(8'h2C);
    for (int i = 0; i <= 240; i++) px(i < 240 ? i : 0, i < 240 ? 0 : 1, 16'($urandom));
    win(8'h2A, 16'h0000, 16'h0000);
    cmd(8'h2C);
    for (int i = 0; i <= 320; i++) px(0, i % 320, 16'($urandom));
    settle();
    chk("cmd_queue_drained", cq.size(), 0);
    chk("pix_queue_drained", pq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
